sad_row_engine: RTL and testbench
=================================

# sad_row_engine

Parametrised sum-of-absolute-differences engine for full-search block matching. It buffers incoming pixel rows (current block plus reference candidate) in an internal row FIFO and computes the SAD of each candidate over a programmable lane count and block height in a fixed-latency pipeline. It also tracks the minimum SAD across a search window and reports the best candidate index. It sits between the frame-memory row fetcher and the motion-vector selection logic.

## Interface
- LANES, 16, pixel pairs per row (power of 2, ≥2)
- PIX_W, 8, pixel width in bits
- ROWS, 16, rows per block (power of 2)
- DEPTH, 16, row FIFO depth in entries (power of 2)
- NUM_CAND, 4, candidates per search window (≥1)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear: flush FIFO, pipeline, counters and best tracker
- run  in  1  pop enable; FIFO pops only while run=1
- in_valid  in  1  row present on in_cur/in_ref
- in_ready  out  1  FIFO can accept a row (= !full)
- in_cur  in  LANES*PIX_W  current-block row, lane 0 in LSBs
- in_ref  in  LANES*PIX_W  reference-candidate row, same packing
- fifo_count  out  clog2(DEPTH+1)  rows held
- sad_valid  out  1  one-cycle pulse: candidate SAD complete
- sad  out  SAD_W  candidate SAD, SAD_W = PIX_W+clog2(LANES)+clog2(ROWS)
- sad_idx  out  CI_W  candidate index of sad, CI_W = max(1,clog2(NUM_CAND))
- best_valid  out  1  one-cycle pulse: search window complete
- best_sad  out  SAD_W  minimum SAD of window
- best_idx  out  CI_W  index of minimum

## Operation
- Push when in_valid && in_ready. Pop when run && !empty.
- Push and pop in the same cycle: count unchanged. in_ready is low when full (push ignored). At empty no pop; the push is accepted.
- Pipeline per popped row: S1 registers |cur[k]-ref[k]| per lane (unsigned, PIX_W bits). S2 registers the lane sum (PIX_W+clog2(LANES) bits). S3 accumulates into a SAD_W register.
- Row counter 0..ROWS-1 advances per S2 row. At row 0 the accumulator loads the row sum instead of adding it. No overflow is possible by the width rule.
- On the S3 update of row ROWS-1: sad_valid=1, sad=final sum, sad_idx=cand counter. The cand counter then increments and wraps NUM_CAND-1→0.
- Best tracker: on sad_valid with sad_idx=0, load best with that SAD. Otherwise replace only if sad < best_sad (strict). Ties keep the earliest index.
- On the cycle after sad_valid with sad_idx=NUM_CAND-1: best_valid=1 with the final best_sad/best_idx. best_sad/best_idx stay held until the next window overwrites them.
- clr: empties FIFO; clears the S1–S3 valid bits, row/cand counters and best registers to 0. Any partial candidate is discarded. Push and pop in the clr cycle are ignored.
- Reset: identical effect to clr, applied asynchronously.

## Timing
- Reset values: in_ready=1, fifo_count=0, sad_valid=0, sad=0, sad_idx=0, best_valid=0, best_sad=0, best_idx=0.
- FIFO is first-word-fall-through. A row pushed at edge e is poppable at edge e+1.
- Latency: sad_valid asserts on the 3rd edge after the edge that pops the last row of a candidate. best_valid asserts one edge later.
- Throughput: one row per cycle sustained. Back-to-back candidates have no bubble.
- run=0 stalls pops only. Rows in flight continue draining through S1–S3.
- sad/sad_idx are valid only while sad_valid=1. sad holds its value otherwise.

## Structure
- Package sad_pkg holds the clog2 function, SAD_W/CI_W derivation functions and the lane pack/unpack index macros.
- Sub-module sad_row_fifo (parameters WIDTH=2*LANES*PIX_W, DEPTH): circular buffer, wrap-around pointers with an extra MSB for full/empty, count output.
- The engine itself contains the abs-diff stage, adder tree, accumulator, counters and best tracker.

## Test plan
- Default parameters, run=1. 16 rows cur=10, ref=7 all lanes -> sad_valid once, sad=768, sad_idx=0, exactly 3 edges after the last pop.
- cur=0, ref=255 all lanes for 16 rows -> sad=65280 (no overflow). Swap cur/ref -> same 65280.
- 4 candidates with SAD 500, 200, 200, 900 back-to-back -> four sad_valid pulses on consecutive candidates; best_valid one edge after idx 3; best_sad=200, best_idx=1.
- run=0, push 17 rows -> fifo_count=16, in_ready=0 after the 16th, 17th held. Raise run -> in_ready=1 next cycle, all 17 rows processed in order, sad correct.
- 7 rows pushed and popped, then clr -> no sad_valid, counters 0. The next 16 rows (cur=1, ref=0) -> sad=256, sad_idx=0.
- rst asserted mid-window (candidate 2, row 5) -> all outputs at reset values immediately. After release, a fresh 4-candidate window reports the correct best_idx.

Source files
------------

// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared width helpers and lane packing macros for the SAD row engine
`ifndef SAD_PKG_LANE_MACROS
`define SAD_PKG_LANE_MACROS
// Part-select of lane k in a packed row whose lanes are w bits wide, lane 0 in LSBs
`define SAD_LANE(k, w) ((k) * (w)) +: (w)
`endif

package sad_pkg;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Width that holds a full block SAD without overflow
    function automatic int sad_w(input int pix_w, input int lanes, input int rows);
        return pix_w + clog2(lanes) + clog2(rows);
    endfunction

    // Counter/index width for n values, never narrower than one bit
    function automatic int ci_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/sad_row_fifo.sv
// rtl/sad_row_fifo.sv - first-word-fall-through row FIFO with wrap-bit pointers
module sad_row_fifo
    import sad_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer MSB distinguishes full from empty when the index bits match
    assign count   = wptr - rptr;
    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (wptr == rptr);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign rdata   = mem[rptr[AW-1:0]];

    // Storage array; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    // Pointer update; clr and reset both collapse the queue to empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW + 1)'(1);
            if (do_pop)  rptr <= rptr + (AW + 1)'(1);
        end
    end

endmodule

// File: rtl/sad_row_engine.sv
// rtl/sad_row_engine.sv - buffered row SAD pipeline with per-window best candidate tracking
module sad_row_engine
    import sad_pkg::*;
#(
    parameter int LANES    = 16,
    parameter int PIX_W    = 8,
    parameter int ROWS     = 16,
    parameter int DEPTH    = 16,
    parameter int NUM_CAND = 4,
    localparam int SAD_W   = sad_w(PIX_W, LANES, ROWS),
    localparam int CI_W    = ci_w(NUM_CAND),
    localparam int CNT_W   = clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   run,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*PIX_W-1:0] in_cur,
    input  logic [LANES*PIX_W-1:0] in_ref,
    output logic [CNT_W-1:0]       fifo_count,
    output logic                   sad_valid,
    output logic [SAD_W-1:0]       sad,
    output logic [CI_W-1:0]        sad_idx,
    output logic                   best_valid,
    output logic [SAD_W-1:0]       best_sad,
    output logic [CI_W-1:0]        best_idx
);

    localparam int ROW_W = LANES * PIX_W;
    localparam int LSW   = PIX_W + clog2(LANES);
    localparam int RW    = ci_w(ROWS);

    logic [2*ROW_W-1:0] fifo_rdata;
    logic [ROW_W-1:0]   row_cur;
    logic [ROW_W-1:0]   row_ref;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    logic [PIX_W-1:0]   abs_d  [LANES];
    logic [PIX_W-1:0]   s1_abs [LANES];
    logic               s1_valid;
    logic [LSW-1:0]     lane_sum;
    logic [LSW-1:0]     s2_sum;
    logic               s2_valid;
    logic [SAD_W-1:0]   acc;
    logic               s3_last;
    logic [RW-1:0]      row_cnt;
    logic [CI_W-1:0]    cand_cnt;

    assign in_ready = !fifo_full;
    assign pop      = run && !fifo_empty;
    assign {row_ref, row_cur} = fifo_rdata;

    sad_row_fifo #(
        .WIDTH (2 * ROW_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (in_valid),
        .wdata ({in_ref, in_cur}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Per-lane unsigned absolute difference of the FIFO head row
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            abs_d[k] = (row_cur[`SAD_LANE(k, PIX_W)] >= row_ref[`SAD_LANE(k, PIX_W)])
                     ? row_cur[`SAD_LANE(k, PIX_W)] - row_ref[`SAD_LANE(k, PIX_W)]
                     : row_ref[`SAD_LANE(k, PIX_W)] - row_cur[`SAD_LANE(k, PIX_W)];
        end
    end

    // S1: capture the lane differences of the row popped this edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            for (int k = 0; k < LANES; k++) s1_abs[k] <= '0;
        end else if (clr) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= pop;
            if (pop) begin
                for (int k = 0; k < LANES; k++) s1_abs[k] <= abs_d[k];
            end
        end
    end

    // Lane reduction; LSW bits cannot overflow for LANES values of PIX_W bits
    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) lane_sum = lane_sum + LSW'(s1_abs[k]);
    end

    // S2: register the row sum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
        end else if (clr) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_sum <= lane_sum;
        end
    end

    // S3: accumulate rows of a block; row 0 restarts the sum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            row_cnt <= '0;
            s3_last <= 1'b0;
        end else if (clr) begin
            acc     <= '0;
            row_cnt <= '0;
            s3_last <= 1'b0;
        end else begin
            s3_last <= s2_valid && (row_cnt == RW'(ROWS - 1));
            if (s2_valid) begin
                acc     <= (row_cnt == '0) ? SAD_W'(s2_sum) : acc + SAD_W'(s2_sum);
                row_cnt <= (row_cnt == RW'(ROWS - 1)) ? '0 : row_cnt + RW'(1);
            end
        end
    end

    // Candidate result: publish the completed block sum and step the candidate index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sad_valid <= 1'b0;
            sad       <= '0;
            sad_idx   <= '0;
            cand_cnt  <= '0;
        end else if (clr) begin
            sad_valid <= 1'b0;
            sad       <= '0;
            sad_idx   <= '0;
            cand_cnt  <= '0;
        end else begin
            sad_valid <= s3_last;
            if (s3_last) begin
                sad      <= acc;
                sad_idx  <= cand_cnt;
                cand_cnt <= (cand_cnt == CI_W'(NUM_CAND - 1)) ? '0 : cand_cnt + CI_W'(1);
            end
        end
    end

    // Best tracker: first candidate of a window loads, later ones replace only on strictly lower SAD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_valid <= 1'b0;
            best_sad   <= '0;
            best_idx   <= '0;
        end else if (clr) begin
            best_valid <= 1'b0;
            best_sad   <= '0;
            best_idx   <= '0;
        end else begin
            best_valid <= sad_valid && (sad_idx == CI_W'(NUM_CAND - 1));
            if (sad_valid && ((sad_idx == '0) || (sad < best_sad))) begin
                best_sad <= sad;
                best_idx <= sad_idx;
            end
        end
    end

endmodule

// File: tb/tb_sad_row_engine.sv
// tb/tb_sad_row_engine.sv - scoreboard bench for sad_row_engine
module tb_sad_row_engine;

    localparam int LANES = 16;
    localparam int PIX_W = 8;
    localparam int W     = LANES * PIX_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          run;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_cur;
    logic [W-1:0]  in_ref;
    logic [4:0]    fifo_count;
    logic          sad_valid;
    logic [15:0]   sad;
    logic [1:0]    sad_idx;
    logic          best_valid;
    logic [15:0]   best_sad;
    logic [1:0]    best_idx;

    sad_row_engine #(
        .LANES (16), .PIX_W (8), .ROWS (16), .DEPTH (16), .NUM_CAND (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .run        (run),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cur     (in_cur),
        .in_ref     (in_ref),
        .fifo_count (fifo_count),
        .sad_valid  (sad_valid),
        .sad        (sad),
        .sad_idx    (sad_idx),
        .best_valid (best_valid),
        .best_sad   (best_sad),
        .best_idx   (best_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_sad_cyc = -100;
    int exp_sad_q[$];
    int exp_idx_q[$];
    int exp_bsad_q[$];
    int exp_bidx_q[$];
    int sad_cyc_q[$];
    logic [W-1:0] cr [16];
    logic [W-1:0] rr [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Monitor: compares every result pulse against the scoreboard queues
    always @(negedge clk) begin
        if (rst && best_valid) begin
            if (exp_bsad_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_best: got best %0d idx %0d, required no pulse", best_sad, best_idx);
            end else begin
                chk("best_sad", best_sad, exp_bsad_q.pop_front());
                chk("best_idx", best_idx, exp_bidx_q.pop_front());
                chk("best_lat", cyc, last_sad_cyc + 1);
            end
        end
        if (rst && sad_valid) begin
            sad_cyc_q.push_back(cyc);
            last_sad_cyc = cyc;
            if (exp_sad_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_sad: got sad %0d idx %0d, required no pulse", sad, sad_idx);
            end else begin
                chk("sad", sad, exp_sad_q.pop_front());
                chk("sad_idx", sad_idx, exp_idx_q.pop_front());
            end
        end
    end

    function automatic logic [W-1:0] rowv(input int v);
        logic [W-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*PIX_W +: PIX_W] = PIX_W'(v);
        return r;
    endfunction

    task automatic clear_cand();
        for (int r = 0; r < 16; r++) begin
            cr[r] = '0;
            rr[r] = '0;
        end
    endtask

    task automatic set_all(input int row, input int c, input int r);
        cr[row] = rowv(c);
        rr[row] = rowv(r);
    endtask

    task automatic set_lane(input int row, input int lane, input int c, input int r);
        cr[row][lane*PIX_W +: PIX_W] = PIX_W'(c);
        rr[row][lane*PIX_W +: PIX_W] = PIX_W'(r);
    endtask

    task automatic push_row(input logic [W-1:0] c, input logic [W-1:0] r);
        int t;
        in_cur   = c;
        in_ref   = r;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) bound_fail("push_ready");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_cand(input int exp_sad, input int exp_idx);
        exp_sad_q.push_back(exp_sad);
        exp_idx_q.push_back(exp_idx);
        for (int r = 0; r < 16; r++) push_row(cr[r], rr[r]);
    endtask

    task automatic expect_best(input int s, input int i);
        exp_bsad_q.push_back(s);
        exp_bidx_q.push_back(i);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_fifo_count"}, fifo_count, 0);
        chk({tag, "_sad_valid"}, sad_valid, 0);
        chk({tag, "_sad"}, sad, 0);
        chk({tag, "_sad_idx"}, sad_idx, 0);
        chk({tag, "_best_valid"}, best_valid, 0);
        chk({tag, "_best_sad"}, best_sad, 0);
        chk({tag, "_best_idx"}, best_idx, 0);
    endtask

    initial begin
        int n0;
        int t;
        rst = 1'b0; clr = 1'b0; run = 1'b0; in_valid = 1'b0;
        in_cur = '0; in_ref = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b1;
        run = 1'b1;
        @(posedge clk); #1;

        // 10 vs 7 on every lane: 16 lanes * 3 * 16 rows = 768, result 3 edges after last pop
        clear_cand();
        for (int r = 0; r < 16; r++) set_all(r, 10, 7);
        send_cand(768, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("lat_early", sad_valid, 0);
        @(posedge clk); #1;
        chk("lat_exact", sad_valid, 1);

        // Full-scale differences both directions, then a tie with candidate 0
        clear_cand();
        for (int r = 0; r < 16; r++) set_all(r, 0, 255);
        send_cand(65280, 1);
        clear_cand();
        for (int r = 0; r < 16; r++) set_all(r, 255, 0);
        send_cand(65280, 2);
        clear_cand();
        for (int r = 0; r < 16; r++) set_all(r, 10, 7);
        expect_best(768, 0);
        send_cand(768, 3);
        repeat (8) @(posedge clk);
        #1;

        // Window 500, 200, 200, 900 back-to-back
        n0 = sad_cyc_q.size();
        clear_cand(); set_all(0, 40, 9); set_lane(1, 3, 0, 4);
        send_cand(500, 0);
        clear_cand(); set_lane(0, 0, 200, 0);
        send_cand(200, 1);
        clear_cand();
        for (int r = 0; r < 8; r++) set_lane(r, 7, 5, 30);
        send_cand(200, 2);
        clear_cand(); set_all(0, 0, 56); set_lane(15, 15, 4, 0);
        expect_best(200, 1);
        send_cand(900, 3);
        repeat (8) @(posedge clk);
        #1;
        if (sad_cyc_q.size() >= n0 + 4) begin
            for (int i = 0; i < 3; i++)
                chk("no_bubble_gap", sad_cyc_q[n0+i+1] - sad_cyc_q[n0+i], 16);
        end else begin
            bound_fail("window_pulses");
        end

        // Stalled FIFO fill: 16 accepted, 17th held until run resumes
        run = 1'b0;
        exp_sad_q.push_back(2176);
        exp_idx_q.push_back(0);
        for (int i = 0; i < 16; i++) push_row(rowv(i + 1), rowv(0));
        chk("full_count", fifo_count, 16);
        chk("full_ready", in_ready, 0);
        in_cur = rowv(1); in_ref = rowv(0); in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("held_count", fifo_count, 16);
        exp_sad_q.push_back(496);
        exp_idx_q.push_back(1);
        run = 1'b1;
        @(posedge clk); #1;
        chk("resume_ready", in_ready, 1);
        push_row(rowv(1), rowv(0));
        for (int i = 0; i < 15; i++) push_row(rowv(2), rowv(0));
        repeat (8) @(posedge clk);
        #1;

        // Partial candidate discarded by clr; push during clr ignored
        for (int i = 0; i < 7; i++) push_row(rowv(9), rowv(0));
        repeat (6) @(posedge clk);
        #1;
        clr = 1'b1; in_valid = 1'b1; in_cur = rowv(200); in_ref = rowv(0);
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_count", fifo_count, 0);
        chk("clr_sad", sad, 0);
        clear_cand();
        for (int r = 0; r < 16; r++) set_all(r, 1, 0);
        send_cand(256, 0);
        repeat (6) @(posedge clk);
        #1;

        // Candidate 1, then reset during candidate 2 row 5
        clear_cand();
        for (int r = 0; r < 16; r++) set_all(r, 3, 1);
        send_cand(512, 1);
        repeat (6) @(posedge clk);
        #1;
        chk("sad_hold", sad, 512);
        for (int i = 0; i < 5; i++) push_row(rowv(4), rowv(0));
        in_cur = rowv(4); in_ref = rowv(0); in_valid = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        check_reset("midrst");
        chk("midrst_pending", exp_sad_q.size(), 0);
        repeat (2) @(posedge clk);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        @(posedge clk); #1;

        // Fresh window 300, 100, 50, 50: tie keeps index 2
        clear_cand(); set_all(0, 18, 0); set_lane(1, 9, 0, 12);
        send_cand(300, 0);
        clear_cand(); set_all(0, 6, 0); set_lane(2, 1, 4, 0);
        send_cand(100, 1);
        clear_cand(); set_lane(3, 2, 100, 50);
        send_cand(50, 2);
        clear_cand(); set_lane(15, 0, 0, 50);
        expect_best(50, 2);
        send_cand(50, 3);

        t = 0;
        while ((exp_sad_q.size() != 0 || exp_bsad_q.size() != 0) && t < 200) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("sad_q_drained", exp_sad_q.size(), 0);
        chk("best_q_drained", exp_bsad_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
